// File: rtl/gf180mcu_fd_sc_mcu9t5v0__addh_sacc.sv
// Bit-serial incrementer: LSB-first half-adder with a carry flop and a one-deep output stage.
// Optional sticky overflow flag enabled by GF180MCU_FD_SC_MCU9T5V0_ADDH_SACC_OVF_EN.
module gf180mcu_fd_sc_mcu9t5v0__addh_sacc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic CLK,
    input  logic RN,
    inout  wire  VDD,
    inout  wire  VSS,
    input  logic A,
    input  logic INC,
    input  logic IV,
    output logic IR,
    input  logic FCLR,
    output logic S,
    output logic OV,
    input  logic OR,
    output logic LAST,
    output logic CO,
    output logic OVF
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_c;
    logic            r_s;
    logic            r_last;
    logic            r_co;
    logic            r_ov;

    logic [CntW-1:0] w_cnt_nxt;
    logic            w_c_nxt;
    logic            w_s_nxt;
    logic            w_last_nxt;
    logic            w_co_nxt;
    logic            w_ov_nxt;

    logic            w_accept;
    logic            w_first;
    logic            w_is_last;
    logic            w_cu;
    logic            w_sum;
    logic            w_carry;
    logic            w_consume;
    logic            w_unused_supply;

    // Supplies are connectivity-only.
    assign w_unused_supply = VDD ^ VSS;

    assign IR        = ~r_ov | OR;
    assign w_accept  = IV & IR;
    assign w_consume = r_ov & OR;
    assign w_first   = (r_cnt == '0);
    assign w_is_last = (r_cnt == LastIdx);
    assign w_cu      = w_first ? INC : r_c;
    assign w_sum     = A ^ w_cu;
    assign w_carry   = A & w_cu;

    // FCLR dominates any accept in the same cycle.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_c_nxt    = r_c;
        w_s_nxt    = r_s;
        w_last_nxt = r_last;
        w_co_nxt   = r_co;
        w_ov_nxt   = r_ov;
        if (FCLR) begin
            w_cnt_nxt  = '0;
            w_c_nxt    = 1'b0;
            w_ov_nxt   = 1'b0;
            w_last_nxt = 1'b0;
            w_co_nxt   = 1'b0;
        end else if (w_accept) begin
            w_s_nxt    = w_sum;
            w_c_nxt    = w_carry;
            w_ov_nxt   = 1'b1;
            w_last_nxt = w_is_last;
            w_co_nxt   = w_is_last & w_carry;
            w_cnt_nxt  = w_is_last ? '0 : r_cnt + 1'b1;
        end else if (OR) begin
            w_ov_nxt   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_s    <= 1'b0;
            r_last <= 1'b0;
            r_co   <= 1'b0;
            r_ov   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_c    <= w_c_nxt;
            r_s    <= w_s_nxt;
            r_last <= w_last_nxt;
            r_co   <= w_co_nxt;
            r_ov   <= w_ov_nxt;
        end
    end

    assign S    = r_s;
    assign OV   = r_ov;
    assign LAST = r_last;
    assign CO   = r_co;

`ifdef GF180MCU_FD_SC_MCU9T5V0_ADDH_SACC_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Sets when a final output carrying CO=1 leaves the stage.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (FCLR) begin
            w_ovf_nxt = 1'b0;
        end else if (w_consume & r_last & r_co) begin
            w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign OVF = r_ovf;
`else
    assign OVF = 1'b0;
`endif

`ifndef SYNTHESIS
    // Held output must not change while downstream stalls.
    property p_hold_on_stall;
        @(posedge CLK) disable iff (!RN)
            (r_ov && !OR && !FCLR) |=> (r_ov && $stable(r_s) && $stable(r_last) && $stable(r_co));
    endproperty
    a_hold_on_stall: assert property (p_hold_on_stall);

    property p_co_only_on_last;
        @(posedge CLK) disable iff (!RN) r_co |-> r_last;
    endproperty
    a_co_only_on_last: assert property (p_co_only_on_last);
`endif

endmodule
